// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose:
//   Adds two WIDTH-bit operands on one shared 4-bit carry-lookahead slice. The
//   slice handles one nibble per clock, least-significant nibble first. A
//   registered carry links each nibble to the next. Operands enter through a
//   valid/ready request port. The result leaves through a valid/ready response
//   port.
//
// Configuration:
//   NSA_SUB_EN  When defined, adds the 'sub' input. With sub=1 at accept, the
//               block computes a - b (mod 2^WIDTH). c_out=1 then means no
//               borrow. When undefined, the block adds only, and the sub port
//               and its logic do not exist.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of 4 and >= 4
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (operands present)
//   in_ready   request ready (high only in IDLE)
//   a, b       operands, sampled on accept
//   c_in       carry-in to nibble 0, sampled on accept
//   sub        subtract select, sampled on accept (NSA_SUB_EN only)
//   out_valid  response valid (high only in DONE)
//   out_ready  response accepted by consumer
//   sum        registered result
//   c_out      registered carry out of bit WIDTH-1
//   busy       high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W+1:0]  nib_base;
    logic [WIDTH-1:0]  sum_r;
    logic              c_out_r;

    logic [WIDTH-1:0]  b_sel;
    logic              cin_sel;
    logic              accept;
    logic              last_nib;
    logic [3:0]        slice_sum;
    logic              slice_co;

    // -------------------------------------------------------------------------
    // 4-bit lookahead slice. Each carry is a flat sum-of-products of p, g and
    // the slice carry-in, so no carry ripples from one bit to the next.
    // -------------------------------------------------------------------------
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    // Operand conditioning at accept: subtraction is a + ~b + 1.
`ifdef NSA_SUB_EN
    assign b_sel   = sub ? ~b : b;
    assign cin_sel = sub | c_in;
`else
    assign b_sel   = b;
    assign cin_sel = c_in;
`endif

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx == LAST_IDX);
    assign nib_base = {idx, 2'b00};

    always_comb begin
        {slice_co, slice_sum} = cla4(a_r[nib_base +: 4], b_r[nib_base +: 4], carry_r);
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The new request cannot be accepted in this same cycle. It
                // is taken in IDLE on the following cycle.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: the operand registers have no reset. They are loaded on every
    // accept and read only in RUN, so reset values could never be observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            carry_r <= cin_sel;
        end else if (state == RUN) begin
            // Nibbles above idx keep their old value until they are computed.
            sum_r[nib_base +: 4] <= slice_sum;
            carry_r              <= slice_co;
            if (last_nib) begin
                idx     <= '0;
                c_out_r <= slice_co;
            end else begin
                idx     <= idx + 1'b1;
            end
        end
    end

    assign sum   = sum_r;
    assign c_out = c_out_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16). It applies a
// table of directed vectors, then hand-written backpressure and mid-run reset
// sequences, then randomized operations. Each result is compared against an
// arithmetic reference model. Subtract vectors are included when NSA_SUB_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;
    localparam int TMO     = 20;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             c_in      = 1'b0;
`ifdef NSA_SUB_EN
    logic             sub       = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef NSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             s;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_co;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain integer arithmetic on WIDTH+1 bits.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci,
                                             input logic s);
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s);
        a    = x;
        b    = y;
        c_in = ci;
`ifdef NSA_SUB_EN
        sub  = s;
`else
        if (s) $display("note: sub requested without NSA_SUB_EN");
`endif
    endtask

    // Present a request and wait (bounded) until it is accepted.
    task automatic start_op(input string name, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic ci, input logic s);
        int t;
        drive(x, y, ci, s);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < TMO) begin
            tick();
            t++;
        end
        if (!in_ready) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge; counts edges until out_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < TMO);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.name, v.a, v.b, v.ci, v.s);
        wait_result(lat);
        check({v.name, "_latency"}, 64'(lat), 64'(NIBBLES));
        check({v.name, "_sum"},     64'(sum), 64'(v.exp_sum));
        check({v.name, "_c_out"},   64'(c_out), 64'(v.exp_co));
        release_result();
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] ra, rb;
        logic        rci, rs;
        int          hold;

        // ---------------- Reset ----------------
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_sum",       64'(sum),       64'h0);
        check("rst_c_out",     64'(c_out),     64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- Directed table ----------------
        vecs.push_back('{"basic",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{"chain_b1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"chain_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"zero",       16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"msb_carry",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"mid_chain",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{"all_ones",   16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0});
`ifdef NSA_SUB_EN
        vecs.push_back('{"sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{"sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{"sub_cin_x",  16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1});
        vecs.push_back('{"sub0_add",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---------------- Backpressure in DONE ----------------
        start_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'(NIBBLES));
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_in_ready", i),  64'(in_ready),  64'd0);
            check($sformatf("bp_hold%0d_sum", i),       64'(sum),       64'h3333);
            check($sformatf("bp_hold%0d_c_out", i),     64'(c_out),     64'd0);
        end
        // Release with in_valid still high: the new request must not be taken
        // in the same cycle.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_busy",      64'(busy),      64'd0);
        tick();
        in_valid = 1'b0;
        check("bp_new_accepted_busy", 64'(busy), 64'd1);
        wait_result(lat);
        check("bp_new_latency", 64'(lat), 64'(NIBBLES));
        check("bp_new_sum",     64'(sum), 64'h1010);
        check("bp_new_c_out",   64'(c_out), 64'd0);
        release_result();

        // ---------------- Reset during nibble idx 2 ----------------
        start_op("mid_rst", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick();   // nibble 0 done
        tick();   // nibble 1 done, nibble 2 in progress
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum",       64'(sum),       64'h0);
        seen = 1'b0;
        tick();
        seen = seen | out_valid;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("mid_rst_no_out_valid", 64'(seen), 64'd0);
        run_vec('{"post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});

        // ---------------- Randomized against model ----------------
        for (int i = 0; i < 40; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rci  = 1'($urandom_range(0, 1));
`ifdef NSA_SUB_EN
            rs   = 1'($urandom_range(0, 1));
`else
            rs   = 1'b0;
`endif
            hold = $urandom_range(0, 3);
            exp  = model(ra, rb, rci, rs);
            start_op($sformatf("rnd%0d", i), ra, rb, rci, rs);
            wait_result(lat);
            check($sformatf("rnd%0d_latency", i), 64'(lat),   64'(NIBBLES));
            check($sformatf("rnd%0d_sum", i),     64'(sum),   64'(exp[WIDTH-1:0]));
            check($sformatf("rnd%0d_c_out", i),   64'(c_out), 64'(exp[WIDTH]));
            if (hold > 0) begin
                repeat (hold) tick();
                check($sformatf("rnd%0d_hold_sum", i),   64'(sum),       64'(exp[WIDTH-1:0]));
                check($sformatf("rnd%0d_hold_valid", i), 64'(out_valid), 64'd1);
            end
            release_result();
            check($sformatf("rnd%0d_drained", i), 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
